// File: rtl/nfa_pkg.sv
// Shared definitions for the NFA character feeder: FSM state codes,
// the flush byte, and a helper that decodes a word's byte count.
package nfa_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SOD     = 3'd1;
    localparam state_t ST_STREAM  = 3'd2;
    localparam state_t ST_FLUSH   = 3'd3;
    localparam state_t ST_CAPTURE = 3'd4;
    localparam state_t ST_REPORT  = 3'd5;

    // Byte fed to the engines after the last packet byte to push the final
    // accept state into their registered sticky output.
    localparam logic [7:0] FLUSH_CHAR = 8'h00;

    // Number of valid bytes in a word (1..4). Only an eop word can be short,
    // and an in_bytes value of 0 means a full word.
    function automatic logic [2:0] byte_limit(input logic eop, input logic [1:0] nbytes);
        if (eop && (nbytes != 2'd0)) begin
            return {1'b0, nbytes};
        end
        return 3'd4;
    endfunction

endpackage

// File: rtl/nfa_word_serializer.sv
// Holds one 32-bit input word and presents it a byte at a time, least
// significant byte first, together with a flag marking its last valid byte.
module nfa_word_serializer
    import nfa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        adv_i,
    input  logic [31:0] data_i,
    input  logic        eop_i,
    input  logic [1:0]  bytes_i,
    output logic [7:0]  byte_o,
    output logic        last_o,
    output logic        eop_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  limit_q, limit_d;
    logic        eop_q, eop_d;

    // Next-state: a load restarts at byte 0; otherwise advance when asked.
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        limit_d = limit_q;
        eop_d   = eop_q;
        if (load_i) begin
            word_d  = data_i;
            idx_d   = 2'd0;
            limit_d = byte_limit(eop_i, bytes_i);
            eop_d   = eop_i;
        end else if (adv_i) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // Word register, byte index and last-byte limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= 32'd0;
            idx_q   <= 2'd0;
            limit_q <= 3'd4;
            eop_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            limit_q <= limit_d;
            eop_q   <= eop_d;
        end
    end

    // Byte select and last-byte detection for the current index.
    always_comb begin
        byte_o = 8'd0;
        case (idx_q)
            2'd0:    byte_o = word_q[7:0];
            2'd1:    byte_o = word_q[15:8];
            2'd2:    byte_o = word_q[23:16];
            default: byte_o = word_q[31:24];
        endcase
        last_o = (({1'b0, idx_q} + 3'd1) == limit_q);
        eop_o  = eop_q;
    end

endmodule

// File: rtl/nfa_char_feeder.sv
// Front end for a bank of NFA engines: serializes packet words onto the
// char/en/sod bus, flushes the engines after the last byte, captures their
// sticky match vector and reports one record per packet.
//
// Handshakes: a word moves when in_valid & in_ready are both high at a rising
// edge; a result moves when res_valid & res_ready are both high. A valid
// side never withdraws its data before the transfer; ready may change freely.
module nfa_char_feeder
    import nfa_pkg::*;
#(
    parameter int N_ENG = 8,
    parameter int LEN_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [1:0]       in_bytes,
    output logic [7:0]       char,
    output logic             en,
    output logic             sod,
    input  logic [N_ENG-1:0] eng_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N_ENG-1:0] res_match,
    output logic [LEN_W-1:0] res_len,
    output logic             res_ovf,
    output logic             err_drop,
    output logic [2:0]       dbg_state
);

    state_t             state_q, state_d;
    logic               wait_q, wait_d;     // STREAM is idle, waiting for the next word
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic [N_ENG-1:0]   match_q, match_d;

    logic               ser_load, ser_adv;
    logic [7:0]         ser_byte;
    logic               ser_last, ser_eop;

    logic               in_ready_c, err_drop_c;

    nfa_word_serializer u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load),
        .adv_i   (ser_adv),
        .data_i  (in_data),
        .eop_i   (in_eop),
        .bytes_i (in_bytes),
        .byte_o  (ser_byte),
        .last_o  (ser_last),
        .eop_o   (ser_eop)
    );

    // Packet FSM: decides outputs, word loads, byte advance and counters.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        match_d    = match_q;
        ser_load   = 1'b0;
        ser_adv    = 1'b0;
        in_ready_c = 1'b0;
        err_drop_c = 1'b0;
        char       = 8'd0;
        en         = 1'b0;
        sod        = 1'b0;
        res_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    if (in_sop) begin
                        ser_load = 1'b1;
                        len_d    = '0;
                        ovf_d    = 1'b0;
                        wait_d   = 1'b0;
                        state_d  = ST_SOD;
                    end else begin
                        err_drop_c = 1'b1;
                    end
                end
            end

            ST_SOD: begin
                sod     = 1'b1;
                state_d = ST_STREAM;
            end

            ST_STREAM: begin
                // While waiting the index is held, so char repeats the last byte.
                char = ser_byte;
                if (wait_q) begin
                    in_ready_c = 1'b1;
                    if (in_valid) begin
                        ser_load = 1'b1;
                        wait_d   = 1'b0;
                    end
                end else begin
                    en = 1'b1;
                    if (len_q == {LEN_W{1'b1}}) begin
                        ovf_d = 1'b1;
                    end else begin
                        len_d = len_q + LEN_W'(1);
                    end
                    if (ser_last) begin
                        if (ser_eop) begin
                            state_d = ST_FLUSH;
                        end else begin
                            // Offer the next word on the last byte so words run back to back.
                            in_ready_c = 1'b1;
                            if (in_valid) begin
                                ser_load = 1'b1;
                            end else begin
                                wait_d = 1'b1;
                            end
                        end
                    end else begin
                        ser_adv = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                en      = 1'b1;
                char    = FLUSH_CHAR;
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                match_d = eng_out;
                state_d = ST_REPORT;
            end

            ST_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            match_q <= match_d;
        end
    end

    // IDLE drives in_ready high, so the handshake outputs are masked during reset.
    always_comb begin
        in_ready  = in_ready_c & ~rst;
        err_drop  = err_drop_c & ~rst;
        res_match = match_q;
        res_len   = len_q;
        res_ovf   = ovf_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_nfa_char_feeder.sv
// Bench for nfa_char_feeder: models a bank of pair-detecting engines,
// drives directed and random packets, and checks the char stream and
// result records against a byte-list reference.
module tb_nfa_char_feeder;
    import nfa_pkg::*;

    localparam int N_ENG = 8;
    localparam int LEN_W = 16;
    localparam int RW    = N_ENG + LEN_W + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_sop;
    logic             in_eop;
    logic [1:0]       in_bytes;
    logic [7:0]       char;
    logic             en;
    logic             sod;
    logic [N_ENG-1:0] eng_out;
    logic             res_valid;
    logic             res_ready;
    logic [N_ENG-1:0] res_match;
    logic [LEN_W-1:0] res_len;
    logic             res_ovf;
    logic             err_drop;
    logic [2:0]       dbg_state;

    int total = 0;
    int bad   = 0;

    logic [7:0]    char_q[$];
    logic [RW-1:0] exp_q[$];
    logic [7:0]    pkt_q[$];

    int         ready_mode = 0;   // 0: ready, 1: not ready, 2: random
    bit         mon_on     = 1'b1;
    int         en_run     = 0;
    int         max_run    = 0;
    int         stall_cnt  = 0;
    logic [7:0] last_char  = 8'd0;
    logic [7:0] mon_exp_c;
    logic [RW-1:0] mon_exp_r;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    nfa_char_feeder #(.N_ENG(N_ENG), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_bytes  (in_bytes),
        .char      (char),
        .en        (en),
        .sod       (sod),
        .eng_out   (eng_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_match (res_match),
        .res_len   (res_len),
        .res_ovf   (res_ovf),
        .err_drop  (err_drop),
        .dbg_state (dbg_state)
    );

    // ---------------- engine bank model ----------------
    // Engine k matches when byte key_a(k) is directly followed by key_b(k).
    function automatic logic [7:0] key_a(input int k);
        case (k)
            0: return 8'h62; 1: return 8'h61; 2: return 8'h62; 3: return 8'h3A;
            4: return 8'h63; 5: return 8'h61; 6: return 8'h62; default: return 8'h63;
        endcase
    endfunction

    function automatic logic [7:0] key_b(input int k);
        case (k)
            0: return 8'h3A; 1: return 8'h62; 2: return 8'h61; 3: return 8'h62;
            4: return 8'h63; 5: return 8'h61; 6: return 8'h62; default: return 8'h3A;
        endcase
    endfunction

    logic [7:0]       eng_prev;
    logic [N_ENG-1:0] eng_acc;

    always @(posedge clk or posedge rst) begin
        if (rst || sod) begin
            eng_prev <= 8'd0;
            eng_acc  <= '0;
            eng_out  <= '0;
        end else if (en) begin
            eng_prev <= char;
            for (int k = 0; k < N_ENG; k++) begin
                eng_acc[k] <= (eng_prev == key_a(k)) && (char == key_b(k));
            end
            eng_out <= eng_out | eng_acc;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [N_ENG-1:0] ref_match();
        logic [N_ENG-1:0] m = '0;
        for (int i = 1; i < pkt_q.size(); i++) begin
            for (int k = 0; k < N_ENG; k++) begin
                if (pkt_q[i-1] == key_a(k) && pkt_q[i] == key_b(k)) m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 3))
            0: return 8'h61; 1: return 8'h62; 2: return 8'h63; default: return 8'h3A;
        endcase
    endfunction

    function automatic logic [7:0] t1_char(input int k);
        case (k)
            2: return 8'h61; 3: return 8'h62; 4: return 8'h3A; 5: return 8'h62;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({char, en, sod, res_valid, res_match, res_len, res_ovf, err_drop, in_ready});
    endfunction

    // ---------------- result consumer ----------------
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'b0;
                default: res_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && mon_on) begin
            check("sod_en_excl", 64'(sod & en), 64'd0);
            if (en) begin
                check("en_state", 64'((dbg_state == ST_STREAM) || (dbg_state == ST_FLUSH)), 64'd1);
                if (char_q.size() == 0) begin
                    fail("char_unexpected");
                end else begin
                    mon_exp_c = char_q.pop_front();
                    check("char", 64'(char), 64'(mon_exp_c));
                end
                last_char = char;
                en_run++;
            end else begin
                if (en_run > max_run) max_run = en_run;
                en_run = 0;
                if (dbg_state == ST_STREAM) begin
                    stall_cnt++;
                    check("stall_char_held", 64'(char), 64'(last_char));
                end
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    fail("result_unexpected");
                end else begin
                    mon_exp_r = exp_q.pop_front();
                    check("result", 64'({res_match, res_len, res_ovf}), 64'(mon_exp_r));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_word(input logic [31:0] d, input logic sop, input logic eop,
                              input logic [1:0] nb);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_bytes = nb;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) fail("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Pushes the expected char stream and result for pkt_q, then sends it.
    // stall < 0: random gap before each continuation word; else fixed gap.
    task automatic send_packet(input int stall);
        int len = pkt_q.size();
        int nw  = (len + 3) / 4;
        logic [31:0] d;
        logic [1:0]  nb;
        int gap;
        foreach (pkt_q[i]) char_q.push_back(pkt_q[i]);
        char_q.push_back(8'h00);
        exp_q.push_back({ref_match(), LEN_W'(len), 1'b0});
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                d[8*b +: 8] = (4*w + b < len) ? pkt_q[4*w + b] : 8'($urandom);
            end
            nb = (w == nw - 1) ? 2'(len - 4*w) : 2'd0;
            if (w > 0 && stall != 0) begin
                gap = (stall < 0) ? int'($urandom_range(0, 8)) : stall;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_word(d, (w == 0), (w == nw - 1), nb);
        end
    endtask

    task automatic rand_packet(input int len);
        pkt_q.delete();
        repeat (len) pkt_q.push_back(rand_char());
    endtask

    task automatic wait_result();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("result_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int g;
        logic [N_ENG-1:0] hold_m;
        logic [LEN_W-1:0] hold_l;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_bytes = 2'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", out_vec(), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word "ab:b": exact cycle timing.
        pkt_q = {8'h61, 8'h62, 8'h3A, 8'h62};
        send_packet(0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t1_sod", 64'(sod), 64'(k == 1));
            check("t1_en", 64'(en), 64'(k >= 2 && k <= 6));
            if (k >= 2 && k <= 6) check("t1_char", 64'(char), 64'(t1_char(k)));
            if (k == 8) begin
                check("t1_res_valid", 64'(res_valid), 64'd1);
                check("t1_match0", 64'(res_match[0]), 64'd1);
                check("t1_len", 64'(res_len), 64'd4);
            end
        end
        wait_result();

        // Two words, 5 bytes, valid held: bytes plus flush run without a gap.
        rand_packet(5);
        max_run = 0;
        send_packet(0);
        wait_result();
        check("twoword_en_run", 64'(max_run), 64'd6);

        // Stall between words: 3 idle cycles in STREAM.
        rand_packet(8);
        stall_cnt = 0;
        send_packet(7);
        wait_result();
        check("stall_cycles", 64'(stall_cnt), 64'd3);

        // Non-sop word in IDLE is dropped.
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_eop   = 1'b1;
        in_data  = $urandom;
        @(negedge clk);
        check("drop_pulse", 64'(err_drop), 64'd1);
        check("drop_no_bus", 64'({sod, en}), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("drop_pulse_end", 64'(err_drop), 64'd0);
        check("drop_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #1;

        // Result held while consumer is not ready.
        ready_mode = 1;
        rand_packet(6);
        send_packet(0);
        g = 0;
        while (!res_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) fail("hold_timeout");
        hold_m = exp_q[0][RW-1 -: N_ENG];
        hold_l = exp_q[0][LEN_W:1];
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_match", 64'(res_match), 64'(hold_m));
            check("hold_len", 64'(res_len), 64'(hold_l));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check("hold_next_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("hold_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of STREAM.
        mon_on = 1'b0;
        drive_word($urandom, 1'b1, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", out_vec(), 64'd0);
        check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        en_run = 0;
        mon_on = 1'b1;
        @(posedge clk);
        #1;
        rand_packet(7);
        send_packet(0);
        wait_result();

        // Random packets with random gaps and random consumer readiness.
        ready_mode = 2;
        repeat (40) begin
            rand_packet($urandom_range(1, 12));
            send_packet(-1);
        end
        wait_result();
        ready_mode = 0;
        check("chars_drained", 64'(char_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nfa_char_feeder.md
Name: nfa_char_feeder

Overview:
- Upstream front end for a bank of generated NFA engines (engine_0 … engine_N-1).
- Accepts packet data as 32-bit words on a valid/ready stream and serializes it one byte per cycle onto the shared char/en/sod bus.
- Flushes the engines' one-stage sticky match output after the last byte, captures the per-engine match vector, and presents one result record per packet on a valid/ready result port.

Parameters:
- N_ENG, 8, number of engines driven and sampled; width of eng_out and res_match.
- LEN_W, 16, width of the packet byte-length counter and res_len.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  32  packet bytes; in_data[7:0] is sent first, in_data[31:24] last.
- in_sop  in  1  first word of packet.
- in_eop  in  1  last word of packet.
- in_bytes  in  2  valid bytes in an eop word; 0 means 4, n means bytes 0..n-1. Ignored when in_eop=0.
- char  out  8  byte to engines.
- en  out  1  engine clock enable.
- sod  out  1  engine state clear (start of data).
- eng_out  in  N_ENG  engine match outputs (registered, sticky).
- res_valid  out  1  result record valid.
- res_ready  in  1  result consumer ready.
- res_match  out  N_ENG  captured eng_out for the packet.
- res_len  out  LEN_W  packet byte count (saturating).
- res_ovf  out  1  byte count saturated.
- err_drop  out  1  one-cycle pulse when a non-sop word is discarded in IDLE.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - char=0, en=0, sod=0, res_valid=0, res_match=0, res_len=0, res_ovf=0, err_drop=0, in_ready=0 while rst is asserted.
  - Any in-flight packet is discarded.
- FSM states: IDLE, SOD, STREAM, FLUSH, CAPTURE, REPORT.
- IDLE:
  - in_ready=1.
  - Accepted word with in_sop=1: load word register, byte index=0, last-byte limit (in_bytes if in_eop else 4), length=0; go to SOD.
  - Accepted word with in_sop=0: discarded, err_drop pulses; stay in IDLE.
- SOD (exactly 1 cycle): sod=1, en=0, char=0; go to STREAM.
- STREAM:
  - en=1; char = byte[index] of the word register; length increments each cycle, saturating at 2^LEN_W-1 and setting res_ovf sticky.
  - in_ready=1 only on the last byte of a non-eop word, giving back-to-back words with no bubble.
  - If no word is available at that point: en=0 and the FSM waits in STREAM, holding index; char is held.
  - in_sop on a continuation word is ignored and treated as data.
  - After the last valid byte of the eop word, go to FLUSH.
- FLUSH (1 cycle): en=1, char=8'h00. This propagates the final accept state into the engines' sticky out register.
- CAPTURE (1 cycle): en=0; eng_out is registered into res_match at the end of the cycle; go to REPORT.
- REPORT:
  - res_valid=1; res_match, res_len and res_ovf are stable.
  - On res_valid & res_ready: clear res_ovf/length and go to IDLE. in_ready=0 throughout.
- Latency, no stalls:
  - Sop word accepted at cycle t; sod at t+1; byte0 at t+2.
  - A packet of L bytes has its last byte at t+1+L, FLUSH at t+2+L, CAPTURE at t+3+L, res_valid at t+4+L.
- Per-packet overhead: 4 cycles plus REPORT hold.
- sod is never asserted together with en.
- en is never high outside STREAM/FLUSH.

Decomposition:
- Shared package nfa_pkg: FSM state enum (6 states, 3-bit) and a constant for the flush byte (8'h00).
- One natural sub-module: nfa_word_serializer (word register, byte index, last-byte limit, per-byte mux). The FSM, counters and result registers stay in the top.

Test Plan:
- Single word "ab:b" (in_data=32'h623A6261), sop=eop=1, in_bytes=0, with engine_0 attached:
  - sod at t+1; chars 61,62,3A,62 at t+2..t+5; flush 00 at t+6.
  - res_valid at t+8 with res_match[0]=1, res_len=4.
- Two-word packet with in_bytes=1 on the eop word and in_valid held high:
  - 5 consecutive en cycles with no bubble between words.
  - res_len=5.
- Stall: drop in_valid for 3 cycles mid-packet:
  - en=0 for exactly those cycles; char held.
  - Byte order and res_len unchanged.
- res_ready held low 10 cycles in REPORT:
  - res_valid and res_match stable; in_ready=0.
  - Next sop is accepted the cycle after the handshake.
- Non-sop word in IDLE: err_drop pulses for 1 cycle; no sod/en activity.
- rst asserted during STREAM:
  - All outputs 0 immediately; state IDLE.
  - After release, a new packet produces a correct result with no residue from the aborted one.
